image_frame_buffer: RTL
=======================

# image_frame_buffer

Parametrised, optionally double-banked successor to the single 30×30 image buffer. It packs a byte stream from the UART/SPI front end into IMG_WIDTH×IMG_HEIGHT bit frames. Each completed frame is handed to the BNN inference core over a valid/ready handshake. With double banking compiled in, the next frame fills while the core still holds the previous one.

## Interface
- IMG_WIDTH, 30, image width in pixels (1 bit per pixel)
- IMG_HEIGHT, 30, image height in pixels
- DATA_W, 8, input word width in bits
- Derived (localparam): IMG_BITS = IMG_WIDTH*IMG_HEIGHT; NWORDS = ceil(IMG_BITS/DATA_W); LAST_BITS = IMG_BITS − (NWORDS−1)*DATA_W; CNT_W = $clog2(NWORDS+1)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- clear_buffer  in  1  synchronous abort: discard all partial and held frames
- in_data  in  DATA_W  input word
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  a bank can accept a word this cycle
- frame_valid  out  1  img_out holds a complete frame
- frame_ready  in  1  consumer releases the presented frame
- img_out  out  IMG_BITS  presented frame; word k at bits [k*DATA_W +: DATA_W]
- byte_count  out  CNT_W  words accepted into the filling bank
- buffer_empty  out  1  filling bank has 0 words and no bank is held
- buffer_full  out  1  equals !in_ready
- overflow  out  1  one-cycle pulse: a word was dropped

## Operation
- Per-bank state: FREE → FILL (first word accepted) → HELD (word NWORDS−1 accepted) → FREE (frame handshake). Pointers wr_sel and rd_sel select the write bank and the read bank.
- Accept condition: in_valid && in_ready. Word k < NWORDS−1 writes all DATA_W bits. Word NWORDS−1 writes only in_data[LAST_BITS−1:0]; its upper bits are ignored. Every frame therefore overwrites all IMG_BITS bits.
- On the accept of word NWORDS−1: the bank goes HELD, byte_count goes to 0, and wr_sel toggles (double-bank only).
- in_ready = 1 iff bank[wr_sel] is FREE or FILL.
- frame_valid = 1 iff bank[rd_sel] is HELD. img_out = bank[rd_sel] and is stable while frame_valid = 1.
- Frame handshake (frame_valid && frame_ready): bank[rd_sel] goes FREE and rd_sel toggles (double-bank only).
- in_valid while in_ready = 0: the word is dropped, state is unchanged, and overflow pulses the next cycle.
- clear_buffer: all banks FREE, wr_sel = rd_sel = 0, byte_count = 0. Bank contents are not zeroed. clear_buffer overrides any accept or handshake in the same cycle.

## Timing
- Reset (rst_n = 0 at an edge): in_ready = 1, frame_valid = 0, overflow = 0, byte_count = 0, buffer_empty = 1, buffer_full = 0. Bank contents are 0, so img_out = 0.
- Latency from the edge accepting the final word to frame_valid = 1 is one cycle, provided bank[rd_sel] was not already HELD.
- After a handshake edge, frame_valid drops the next cycle. The exception is when the other bank is HELD: frame_valid then stays 1 with the new frame, giving back-to-back frames.
- Simultaneous final-word accept and handshake on the same edge:
  - Both take effect.
  - Double-bank: in_ready stays 1 if the freed bank is the new wr_sel.
  - Single-bank: only possible on different frames, which cannot happen, so it is unreachable.
- Single-bank: in_ready is 0 from the cycle after the final accept until the cycle after the handshake.
- rst_n or clear_buffer mid-frame discards the partial frame. The next accepted word is word 0.

## Configuration
- IMAGE_FRAME_BUF_DOUBLE_BANK_EN defined: two banks, ping-pong as above; in_ready falls only when both banks are HELD.
- Not defined: one bank, wr_sel/rd_sel fixed at 0; writing stalls (in_ready = 0) from frame completion until the handshake. Interface is identical in both builds.

## Test plan
- Defaults, single-bank: 113 words 0xA5…, last word 0xFF → frame_valid = 1 one cycle later; img_out[899:896] = 4'hF; byte_count = 0; in_ready = 0.
- Single-bank: word 114 pushed while frame held, no handshake → overflow pulse, img_out unchanged; after frame_ready, in_ready = 1 next cycle.
- Double-bank: two frames streamed back to back, frame_ready = 0 → in_ready stays 1 through word 113 of frame 1, drops after frame 2 completes; two handshakes give frame 1, then frame 2, with frame_valid continuous.
- clear_buffer asserted after 50 words → byte_count = 0 and buffer_empty = 1 next cycle; 113 fresh words produce a correct frame.
- rst_n = 0 for one cycle while a frame is held → all outputs at reset values next cycle; img_out = 0.
- IMG_WIDTH = 4, IMG_HEIGHT = 3, DATA_W = 8 (NWORDS = 2, LAST_BITS = 4): words 0x3C, 0xF7 → img_out = 12'h73C.

Source files
------------

// File: rtl/image_frame_buffer_if.sv
// image_frame_buffer_if: generic valid/ready stream bundle of width W.
// master drives data/valid and samples ready; slave does the reverse.
interface image_frame_buffer_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/image_frame_buffer.sv
// image_frame_buffer: packs DATA_W words into IMG_WIDTH x IMG_HEIGHT bit
// frames and presents each complete frame over a valid/ready handshake.
// Ports: clk, rst_n (sync, active-low), clear_buffer (sync abort),
//   in_if  (slave)  : data=in_data, valid=in_valid, ready=in_ready
//   out_if (master) : data=img_out, valid=frame_valid, ready=frame_ready
//   byte_count, buffer_empty, buffer_full, overflow : status outputs
// Define IMAGE_FRAME_BUF_DOUBLE_BANK_EN for two ping-pong banks;
// otherwise one bank, and writing stalls until the frame is released.
module image_frame_buffer #(
  parameter  int IMG_WIDTH  = 30,
  parameter  int IMG_HEIGHT = 30,
  parameter  int DATA_W     = 8,
  localparam int IMG_BITS   = IMG_WIDTH * IMG_HEIGHT,
  localparam int NWORDS     = (IMG_BITS + DATA_W - 1) / DATA_W,
  localparam int LAST_BITS  = IMG_BITS - (NWORDS - 1) * DATA_W,
  localparam int CNT_W      = $clog2(NWORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_buffer,
  image_frame_buffer_if.slave  in_if,
  image_frame_buffer_if.master out_if,
  output logic [CNT_W-1:0]     byte_count,
  output logic                 buffer_empty,
  output logic                 buffer_full,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILL,
    BANK_HELD
  } bank_st_e;

`ifdef IMAGE_FRAME_BUF_DOUBLE_BANK_EN
  localparam logic PING_PONG = 1'b1;
`else
  localparam logic PING_PONG = 1'b0;
`endif

  // Storage is declared for two banks; without ping-pong the
  // selectors never leave 0, so bank 1 stays constant at reset.
  bank_st_e            st_q   [2];
  bank_st_e            st_d   [2];
  logic [IMG_BITS-1:0] bank_q [2];
  logic [IMG_BITS-1:0] bank_d [2];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wr_sel_q;
  logic             wr_sel_d;
  logic             rd_sel_q;
  logic             rd_sel_d;
  logic             overflow_q;
  logic             overflow_d;

  logic in_ready;
  logic frame_valid;
  logic accept;
  logic handshake;
  logic last_word;
  logic any_held;

  always_comb begin
    in_ready    = st_q[wr_sel_q] != BANK_HELD;
    frame_valid = st_q[rd_sel_q] == BANK_HELD;
    accept      = in_if.valid && in_ready;
    handshake   = frame_valid && out_if.ready;
    last_word   = cnt_q == CNT_W'(NWORDS - 1);
    any_held    = (st_q[0] == BANK_HELD) ||
                  (st_q[1] == BANK_HELD);

    st_d       = st_q;
    bank_d     = bank_q;
    cnt_d      = cnt_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    overflow_d = in_if.valid && !in_ready;

    // Handshake and accept never target the same bank: one needs
    // HELD, the other needs not-HELD.
    if (handshake) begin
      st_d[rd_sel_q] = BANK_FREE;
      rd_sel_d       = rd_sel_q ^ PING_PONG;
    end

    if (accept) begin
      for (int k = 0; k < NWORDS - 1; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          bank_d[wr_sel_q][k*DATA_W +: DATA_W] = in_if.data;
        end
      end
      if (last_word) begin
        bank_d[wr_sel_q][(NWORDS-1)*DATA_W +: LAST_BITS] =
          in_if.data[LAST_BITS-1:0];
        st_d[wr_sel_q] = BANK_HELD;
        cnt_d          = '0;
        wr_sel_d       = wr_sel_q ^ PING_PONG;
      end else begin
        st_d[wr_sel_q] = BANK_FILL;
        cnt_d          = cnt_q + CNT_W'(1);
      end
    end

    // Abort wins over everything; bank contents are left in place.
    if (clear_buffer) begin
      st_d[0]  = BANK_FREE;
      st_d[1]  = BANK_FREE;
      cnt_d    = '0;
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= BANK_FREE;
        bank_q[i] <= '0;
      end
      cnt_q      <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      bank_q     <= bank_d;
      cnt_q      <= cnt_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = frame_valid;
  assign out_if.data  = bank_q[rd_sel_q];
  assign byte_count   = cnt_q;
  assign buffer_empty = (cnt_q == '0) && !any_held;
  assign buffer_full  = !in_ready;
  assign overflow     = overflow_q;

endmodule
